// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_pkg
// Description : Shared types for the configurable UART receiver: FSM state
//               encoding, parity mode and the parity check helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Receiver FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   // Parity sense; the value equals the XOR of data and parity bits that
   // constitutes a correct frame.
   typedef enum logic {
      PAR_EVEN = 1'b0,
      PAR_ODD  = 1'b1
   } parity_mode_t;

   // Width of the bit counter: large enough for 9 data bits
   localparam int c_bit_cnt_w = 4;

   // True when the received parity bit does not match the selected mode
   function automatic logic parity_fail(input logic         data_xor,
                                        input logic         par_bit,
                                        input parity_mode_t mode);
      return (data_xor ^ par_bit) != logic'(mode);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tmr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_baud_tmr
// Description : Down-counting bit-period timer. A load sets the count; the
//               counter then decrements to zero and holds there. expire is
//               high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tmr #(
   parameter int CNT_W = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] r_cnt;

   // Load on request, otherwise count down and park at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign expire = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_rx_cfg
// Description : Parameterised UART receiver. Synchronises RX, detects the
//               start edge, samples each bit at mid-period, checks optional
//               parity and 1 or 2 stop bits, and presents the payload with
//               ready / error / overrun flags until acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int BAUD_DIV   = 2604,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RX,
   input  logic                 clr_rdy,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rdy,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 receiving
);

   localparam int                       c_cnt_w     = $clog2(BAUD_DIV);
   localparam logic [c_cnt_w-1:0]       c_half      = c_cnt_w'(BAUD_DIV / 2);
   localparam logic [c_cnt_w-1:0]       c_full      = c_cnt_w'(BAUD_DIV - 1);
   localparam logic [c_bit_cnt_w-1:0]   c_last_data = c_bit_cnt_w'(DATA_BITS - 1);
   localparam logic [c_bit_cnt_w-1:0]   c_last_stop = c_bit_cnt_w'(STOP_BITS - 1);
   localparam parity_mode_t             c_par_mode  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

   // Synchroniser and start-edge detection
   logic [1:0] r_sync;
   logic       r_prev;
   logic [2:0] r_settle;
   logic       w_rx;
   logic       w_fall;

   // FSM state
   rx_state_t                r_state;
   logic [c_bit_cnt_w-1:0]   r_bit_cnt;
   logic [DATA_BITS-1:0]     r_shift;
   logic                     r_par_err;
   logic                     r_frm_err;

   // FSM next-state values
   rx_state_t                w_state_nxt;
   logic [c_bit_cnt_w-1:0]   w_bit_cnt_nxt;
   logic [DATA_BITS-1:0]     w_shift_nxt;
   logic                     w_par_nxt;
   logic                     w_ferr_nxt;
   logic                     w_tmr_load;
   logic [c_cnt_w-1:0]       w_tmr_val;
   logic                     w_done;
   logic                     w_expire;

   // Registered outputs
   logic [DATA_BITS-1:0]     r_rx_data;
   logic                     r_rdy;
   logic                     r_parity_err;
   logic                     r_frame_err;
   logic                     r_overrun;
   logic                     r_receiving;

   // Two-flop synchroniser; r_settle keeps the reset value of the chain from
   // being mistaken for a falling edge when the line is already low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync   <= 2'b11;
         r_prev   <= 1'b1;
         r_settle <= 3'b000;
      end else begin
         r_sync   <= {r_sync[0], RX};
         r_prev   <= r_sync[1];
         r_settle <= {r_settle[1:0], 1'b1};
      end
   end

   assign w_rx   = r_sync[1];
   assign w_fall = r_settle[2] & r_prev & ~w_rx;

   uart_baud_tmr #(
      .CNT_W    (c_cnt_w)
   ) u_baud_tmr (
      .clk      (clk),
      .rst      (rst),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .expire   (w_expire)
   );

   // FSM state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_par_err <= 1'b0;
         r_frm_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_par_err <= w_par_nxt;
         r_frm_err <= w_ferr_nxt;
      end
   end

   // FSM next-state logic: every sample is taken when the baud timer expires
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_par_nxt     = r_par_err;
      w_ferr_nxt    = r_frm_err;
      w_tmr_load    = 1'b0;
      w_tmr_val     = c_full;
      w_done        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_fall) begin
               w_state_nxt   = ST_START;
               w_tmr_load    = 1'b1;
               w_tmr_val     = c_half;
               w_bit_cnt_nxt = '0;
               w_par_nxt     = 1'b0;
               w_ferr_nxt    = 1'b0;
            end
         end
         ST_START: begin
            if (w_expire) begin
               if (w_rx) begin
                  // Line back high at mid start bit: treat as a glitch
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt   = ST_DATA;
                  w_tmr_load    = 1'b1;
                  w_bit_cnt_nxt = '0;
               end
            end
         end
         ST_DATA: begin
            if (w_expire) begin
               w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
               w_tmr_load  = 1'b1;
               if (r_bit_cnt == c_last_data) begin
                  w_bit_cnt_nxt = '0;
                  w_state_nxt   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + c_bit_cnt_w'(1);
               end
            end
         end
         ST_PARITY: begin
            if (w_expire) begin
               w_par_nxt     = parity_fail(^r_shift, w_rx, c_par_mode);
               w_tmr_load    = 1'b1;
               w_bit_cnt_nxt = '0;
               w_state_nxt   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_expire) begin
               w_ferr_nxt = r_frm_err | ~w_rx;
               if (r_bit_cnt == c_last_stop) begin
                  w_done      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + c_bit_cnt_w'(1);
                  w_tmr_load    = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output registers: frame completion takes priority over acknowledge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_data    <= '0;
         r_rdy        <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_receiving  <= 1'b0;
      end else begin
         r_receiving <= (w_state_nxt != ST_IDLE);
         if (w_done) begin
            r_rx_data    <= r_shift;
            r_parity_err <= r_par_err;
            r_frame_err  <= w_ferr_nxt;
            r_rdy        <= 1'b1;
            r_overrun    <= r_rdy & ~clr_rdy;
         end else if (clr_rdy) begin
            r_rdy        <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
         end
      end
   end

   assign rx_data    = r_rx_data;
   assign rdy        = r_rdy;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;
   assign receiving  = r_receiving;

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL expose parameter DATA_BITS, default 8, meaning payload bits per frame (legal range 5..9).
REQ-002 The block SHALL expose parameter BAUD_DIV, default 2604, meaning clk cycles per bit period (legal range 8..65535).
REQ-003 The block SHALL expose parameter PARITY_EN, default 0, meaning a parity bit follows the data when 1.
REQ-004 The block SHALL expose parameter PARITY_ODD, default 0, meaning odd parity when 1 and even parity when 0; it is ignored when PARITY_EN=0.
REQ-005 The block SHALL expose parameter STOP_BITS, default 1, meaning stop bits checked per frame (1 or 2).
REQ-006 The block SHALL have these ports:
- clk, input, 1 bit: single system clock, rising edge.
- rst, input, 1 bit: asynchronous active-high reset.
- RX, input, 1 bit: serial line, asynchronous to clk, idle high.
- clr_rdy, input, 1 bit: consumer acknowledge; clears rdy and all flags.
- rx_data, output, DATA_BITS wide: last received payload, LSB first on the line.
- rdy, output, 1 bit: frame available.
- parity_err, output, 1 bit: parity mismatch on the last frame.
- frame_err, output, 1 bit: a stop bit sampled low on the last frame.
- overrun, output, 1 bit: a frame completed while rdy was already high.
- receiving, output, 1 bit: high while in any state other than IDLE.

Function
REQ-007 RX SHALL pass through a two-flop synchronizer whose flops reset to 1, giving 2 cycles of input latency.
REQ-008 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, plus a bit counter and a baud counter of width $clog2(BAUD_DIV).
REQ-009 IDLE -> START SHALL occur on a synchronized falling edge of RX; the baud counter loads BAUD_DIV/2 (integer division).
REQ-010 In START at baud-counter expiry, the block SHALL sample RX: if RX=1 (glitch), go to IDLE with no flag change; if RX=0, go to DATA with the counter reloaded to BAUD_DIV-1.
REQ-011 In DATA, each expiry SHALL shift the sampled bit into bit position DATA_BITS-1 of a shift register (LSB-first order); after DATA_BITS samples, go to PARITY if PARITY_EN=1, else go to STOP.
REQ-012 PARITY SHALL sample one bit and compute the error as XOR(data bits, parity bit) != PARITY_ODD.
REQ-013 STOP SHALL sample STOP_BITS bits, one bit period apart; any sample of 0 SHALL set the frame-error result for this frame.
REQ-014 On the cycle after the final stop sample, the block SHALL:
- load rx_data,
- load parity_err and frame_err with this frame's results,
- assert rdy,
- return to IDLE.
REQ-015 A frame with frame_err=1 SHALL still assert rdy and update rx_data.
REQ-016 If a frame completes while rdy=1 and clr_rdy=0, the block SHALL overwrite rx_data and set overrun.
REQ-017 If clr_rdy and frame completion occur in the same cycle, completion SHALL win: rdy=1, flags hold the new frame's values, overrun=0.
REQ-018 clr_rdy alone SHALL clear rdy, parity_err, frame_err and overrun on the next edge.
REQ-019 After returning to IDLE, the block SHALL detect a new start edge with no idle gap beyond the stop bit.
REQ-020 clr_rdy SHALL never affect reception in progress.

Reset
REQ-021 Asserting rst SHALL immediately force state=IDLE, rx_data=0, rdy=0, parity_err=0, frame_err=0, overrun=0, receiving=0, both counters to 0 and the synchronizer flops to 1.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame.
REQ-023 After reset release, a line that is already low SHALL NOT start a frame until a falling edge is seen.

Structure
REQ-024 The state enum and a parity-mode enum SHALL reside in shared package uart_pkg.
REQ-025 The baud counter SHALL be a sub-module uart_baud_tmr, with inputs load and load_val and output expire.
REQ-026 The FSM SHALL be coded with separate sequential and combinational processes, with default assignments in the combinational process.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- DATA_BITS=8, BAUD_DIV=16, 8N1, send 0xA5 -> rx_data=0xA5, rdy rises 154 +/-2 cycles after the RX falling edge, all flags 0.
- PARITY_EN=1, even parity, send 0x07 with parity bit 0 -> parity_err=1, rx_data=0x07; repeat with parity bit 1 -> parity_err=0.
- STOP_BITS=2, second stop bit driven 0 -> frame_err=1, rdy=1.
- Send two frames 0x11 then 0x22 without clr_rdy -> rx_data=0x22, overrun=1; pulsing clr_rdy clears rdy and overrun.
- 4-cycle low glitch on RX with BAUD_DIV=16 -> return to IDLE, rdy stays 0, receiving high for at most 11 cycles.
- rst asserted at data bit 3, then 0x3C sent -> rx_data=0x3C, no flags.
